data_mem_pipe: RTL

Parametrised, pipelined successor to the core's data memory: a word-organised RAM behind a valid/ready request port and a valid/ready response port. It adds configurable read latency, sign/zero-extended sub-word loads, access fault reporting (misaligned, out-of-range, bad size), response backpressure and a hardware clear sequencer after reset. It sits between the MEM stage / LSU and on-chip data storage.

---
 rtl/data_mem_pipe_pkg.sv | 54 +++++
 rtl/data_mem_pipe_lane.sv | 46 ++++
 rtl/data_mem_pipe.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/data_mem_pipe_pkg.sv
// Shared types for the pipelined data memory: access size, fault codes, FSM state and pipeline stage.
// Also holds the request fault classifier so the priority order lives in one place.
package data_mem_pipe_pkg;

    typedef enum logic [1:0] {
        MEM_SZ_BYTE  = 2'd0,
        MEM_SZ_HWORD = 2'd1,
        MEM_SZ_WORD  = 2'd2
    } mem_op_sz_e;

    typedef enum logic [1:0] {
        MEM_OK        = 2'd0,
        MEM_ERR_ALIGN = 2'd1,
        MEM_ERR_RANGE = 2'd2,
        MEM_ERR_SIZE  = 2'd3
    } mem_err_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dmem_state_e;

    // raw is already zero for stores and faulted loads, so the response side needs no extra gating
    typedef struct packed {
        logic        vld;
        mem_err_e    err;
        logic [1:0]  lane;
        mem_op_sz_e  size;
        logic        uns;
        logic [31:0] raw;
    } pipe_stage_t;

    function automatic mem_err_e check_access(input logic [31:0] addr,
                                              input mem_op_sz_e  size,
                                              input logic [31:0] byte_cap);
        mem_err_e err;
        logic     size_ok;
        err = MEM_OK;
        case (size)
            MEM_SZ_BYTE, MEM_SZ_HWORD, MEM_SZ_WORD: size_ok = 1'b1;
            default:                                size_ok = 1'b0;
        endcase
        if (!size_ok) begin
            err = MEM_ERR_SIZE;
        end else if (addr >= byte_cap) begin
            err = MEM_ERR_RANGE;
        end else if ((size == MEM_SZ_HWORD && addr[0]) ||
                     (size == MEM_SZ_WORD && addr[1:0] != 2'b00)) begin
            err = MEM_ERR_ALIGN;
        end
        return err;
    endfunction

endpackage

// File: rtl/data_mem_pipe_lane.sv
// Combinational byte-lane steering: store byte enables and replicated write data, plus load lane
// select with sign/zero extension. Zero latency, no flow control of its own.
module mem_lane_align
    import data_mem_pipe_pkg::*;
(
    input  mem_op_sz_e  i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rword[{i_lane, 3'b000} +: 8];
    assign w_half = i_lane[1] ? i_rword[31:16] : i_rword[15:0];

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = 32'h0;
        o_rdata = 32'h0;
        case (i_size)
            MEM_SZ_BYTE: begin
                o_be    = 4'b0001 << i_lane;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            end
            MEM_SZ_HWORD: begin
                o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{w_half[15] & ~i_unsigned}}, w_half};
            end
            MEM_SZ_WORD: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_pipe.sv
// Word RAM behind valid/ready request/response ports; response ReadLatency cycles after accept.
// A held response (valid && !ready) freezes the whole pipeline and deasserts o_req_ready.
module data_mem_pipe
    import data_mem_pipe_pkg::*;
#(
    parameter int DepthWords   = 256,
    parameter int ReadLatency  = 1,
    parameter bit ClearOnReset = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  mem_op_sz_e  i_req_size,
    input  logic        i_req_unsigned,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output mem_err_e    o_rsp_err,
    output logic        o_init_done
);

    localparam int          AW      = $clog2(DepthWords);
    localparam logic [31:0] ByteCap = 32'(DepthWords * 4);

    dmem_state_e   r_state;
    dmem_state_e   w_state_nxt;
    logic [AW-1:0] r_clr_cnt;
    logic [AW-1:0] w_clr_cnt_nxt;
    logic [31:0]   r_mem [DepthWords];

    logic          w_stall;
    logic          w_adv;
    logic          w_acc;
    logic          w_wr_en;
    logic          w_clr_en;
    mem_err_e      w_req_err;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_sh;
    logic [31:0]   w_rsp_rdata;
    logic [31:0]   w_unused_req_rdata;
    logic [3:0]    w_unused_rsp_be;
    logic [31:0]   w_unused_rsp_wdata;
    pipe_stage_t   w_stage_in;
    pipe_stage_t   w_stage_out;

    // i_rsp_ready reaches o_req_ready combinationally through the stall term
    assign w_stall     = o_rsp_valid && !i_rsp_ready;
    assign w_adv       = !w_stall;
    assign o_req_ready = (r_state == RUN) && !w_stall;
    assign o_init_done = (r_state == RUN);

    assign w_acc     = i_req_valid && o_req_ready;
    assign w_req_err = check_access(i_req_addr, i_req_size, ByteCap);
    assign w_idx     = i_req_addr[AW+1:2];
    assign w_wr_en   = w_acc && i_req_we && (w_req_err == MEM_OK);
    assign w_clr_en  = (r_state == INIT) && ClearOnReset;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= INIT;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            INIT: begin
                if (!ClearOnReset) begin
                    w_state_nxt = RUN;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + AW'(1);
                    if (r_clr_cnt == AW'(DepthWords - 1)) begin
                        w_state_nxt = RUN;
                    end
                end
            end
            RUN:     ;
            default: w_state_nxt = INIT;
        endcase
    end

    mem_lane_align u_req_align (
        .i_size     (i_req_size),
        .i_lane     (i_req_addr[1:0]),
        .i_unsigned (i_req_unsigned),
        .i_wdata    (i_req_wdata),
        .i_rword    (32'h0),
        .o_be       (w_be),
        .o_wdata    (w_wdata_sh),
        .o_rdata    (w_unused_req_rdata)
    );

    // Reset blocks the write so a store accepted on the reset edge never lands
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (w_clr_en) begin
                r_mem[r_clr_cnt] <= '0;
            end else if (w_wr_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) begin
                        r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        w_stage_in = '0;
        if (w_acc) begin
            w_stage_in.vld  = 1'b1;
            w_stage_in.err  = w_req_err;
            w_stage_in.lane = i_req_addr[1:0];
            w_stage_in.size = i_req_size;
            w_stage_in.uns  = i_req_unsigned;
            if (!i_req_we && w_req_err == MEM_OK) begin
                w_stage_in.raw = r_mem[w_idx];
            end
        end
    end

    for (genvar s = 0; s < ReadLatency; s++) begin : g_stage
        pipe_stage_t r_q;
        pipe_stage_t w_d;
        if (s == 0) begin : g_first
            assign w_d = w_stage_in;
        end else begin : g_next
            assign w_d = g_stage[s-1].r_q;
        end
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_q <= '0;
            end else if (w_adv) begin
                r_q <= w_d;
            end
        end
    end

    assign w_stage_out = g_stage[ReadLatency-1].r_q;

    mem_lane_align u_rsp_align (
        .i_size     (w_stage_out.size),
        .i_lane     (w_stage_out.lane),
        .i_unsigned (w_stage_out.uns),
        .i_wdata    (32'h0),
        .i_rword    (w_stage_out.raw),
        .o_be       (w_unused_rsp_be),
        .o_wdata    (w_unused_rsp_wdata),
        .o_rdata    (w_rsp_rdata)
    );

    assign o_rsp_valid = w_stage_out.vld;
    assign o_rsp_err   = w_stage_out.err;
    assign o_rsp_data  = w_rsp_rdata;

endmodule
